// File: rtl/if_fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues single-outstanding word reads, buffers {pc, instr} in a DEPTH-entry queue.
// Latency: request 1 cycle after enable/redirect; pushed word reaches the queue head 1 cycle after its ack edge (no bypass).
// Backpressure: consumer stalls via instr_ready_i; fetch stops issuing when the queue would be full; redirect flushes everything.
module if_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_instr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW:0]    DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]  PTR_ONE = (AW)'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_fetch_pc, w_fetch_pc_nxt;
  logic [31:0]   r_pend_pc, w_pend_pc_nxt;
  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr, r_wr_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_nxt;
  logic [AW:0]   w_push_ext, w_pop_ext;
  logic [31:0]   w_redir_pc;
  logic          w_push, w_pop, w_can_issue;

  // Redirect targets are always word aligned.
  assign w_redir_pc = redirect_pc_i & 32'hFFFF_FFFC;

  assign imem_addr_o   = r_fetch_pc;
  assign imem_req_o    = (r_state == S_WAIT) || (r_state == S_DROP);
  assign instr_valid_o = (r_count != '0);
  assign instr_o       = r_mem[r_rd_ptr][31:0];
  assign instr_pc_o    = r_mem[r_rd_ptr][63:32];

  // A redirect suppresses both queue operations; the flush takes priority.
  assign w_push      = (r_state == S_WAIT) && imem_ack_i && !redirect_i;
  assign w_pop       = instr_valid_o && instr_ready_i && !redirect_i;
  assign w_push_ext  = {{AW{1'b0}}, w_push};
  assign w_pop_ext   = {{AW{1'b0}}, w_pop};
  assign w_count_nxt = r_count + w_push_ext - w_pop_ext;
  // Only one request is ever in flight, so checking the post-update count is enough to avoid overflow.
  assign w_can_issue = start_i && (w_count_nxt < DEPTH_C);

  // Fetch FSM next-state and fetch/pending PC updates.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_pend_pc_nxt  = r_pend_pc;
    case (r_state)
      S_IDLE: begin
        if (redirect_i) begin
          w_fetch_pc_nxt = w_redir_pc;
        end else if (w_can_issue) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_i) begin
          if (imem_ack_i) begin
            w_fetch_pc_nxt = w_redir_pc;
            w_state_nxt    = S_IDLE;
          end else begin
            // Request cannot be withdrawn: keep the address, remember the target.
            w_pend_pc_nxt = w_redir_pc;
            w_state_nxt   = S_DROP;
          end
        end else if (imem_ack_i) begin
          w_fetch_pc_nxt = r_fetch_pc + 32'd4;
          w_state_nxt    = w_can_issue ? S_WAIT : S_IDLE;
        end
      end
      S_DROP: begin
        if (redirect_i) begin
          w_pend_pc_nxt = w_redir_pc;
        end
        if (imem_ack_i) begin
          // The newest redirect target wins, even one arriving with the ack.
          w_fetch_pc_nxt = redirect_i ? w_redir_pc : r_pend_pc;
          w_state_nxt    = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state and PC registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_pend_pc  <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_pend_pc  <= w_pend_pc_nxt;
    end
  end

  // Queue pointers and occupancy; redirect flushes in the same edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count <= w_count_nxt;
    end
  end

  // Queue storage: {pc, instr} written at the tail on each accepted response.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= {r_fetch_pc, imem_instr_i};
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: table of per-cycle inputs and expected outputs, plus hand-written reset sequences.
// Latency: expectations are the outputs observed in each cycle before the next rising edge.
// Backpressure: ready and ack are driven directly from the table rows.
module tb_if_fetch_queue;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_instr_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  int checks   = 0;
  int failures = 0;

  if_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_instr_i  (imem_instr_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Memory model: data is a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_instr_i = mem_word(imem_addr_o);

  typedef struct {
    bit          rst;
    logic        start;
    logic        ack;
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, input logic st, input logic ack, input logic rdy,
                     input logic rd, input logic [31:0] rpc, input logic ereq,
                     input logic [31:0] eaddr, input logic ev, input logic [31:0] epc);
    vec_t v;
    v.rst = rst; v.start = st; v.ack = ack; v.ready = rdy; v.redir = rd; v.rpc = rpc;
    v.ereq = ereq; v.eaddr = eaddr; v.evalid = ev; v.epc = epc;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic ereq, input logic [31:0] eaddr,
                               input logic ev, input logic [31:0] epc);
    check({tag, " req"},   {31'b0, imem_req_o},    {31'b0, ereq});
    check({tag, " addr"},  imem_addr_o,            eaddr);
    check({tag, " valid"}, {31'b0, instr_valid_o}, {31'b0, ev});
    if (ev) begin
      check({tag, " pc"},    instr_pc_o, epc);
      check({tag, " instr"}, instr_o,    mem_word(epc));
    end
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0; imem_ack_i = 1'b0; redirect_i = 1'b0;
    redirect_pc_i = 32'h0; instr_ready_i = 1'b0;

    //   rst st ack rdy rd rpc          req addr         v  pc
    // Streaming with zero-wait memory, one instruction per cycle.
    add(1, 1, 1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0);
    add(0, 1, 1, 1, 0, 32'h0,        1, 32'h0,        0, 32'h0);
    add(0, 1, 1, 1, 0, 32'h0,        1, 32'h4,        1, 32'h0);
    add(0, 1, 1, 1, 0, 32'h0,        1, 32'h8,        1, 32'h4);
    add(0, 1, 1, 1, 0, 32'h0,        1, 32'hC,        1, 32'h8);
    add(0, 1, 1, 1, 0, 32'h0,        1, 32'h10,       1, 32'hC);
    // Fill to full with ready low, one pop reissues at 16, then redirect with ack+pop.
    add(1, 1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0);
    add(0, 1, 1, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0);
    add(0, 1, 1, 0, 0, 32'h0,        1, 32'h4,        1, 32'h0);
    add(0, 1, 1, 0, 0, 32'h0,        1, 32'h8,        1, 32'h0);
    add(0, 1, 1, 0, 0, 32'h0,        1, 32'hC,        1, 32'h0);
    add(0, 1, 1, 0, 0, 32'h0,        0, 32'h10,       1, 32'h0);
    add(0, 1, 1, 1, 0, 32'h0,        0, 32'h10,       1, 32'h0);
    add(0, 1, 1, 1, 1, 32'h203,      1, 32'h10,       1, 32'h4);
    add(0, 1, 0, 0, 0, 32'h0,        0, 32'h200,      0, 32'h0);
    add(0, 1, 0, 0, 0, 32'h0,        1, 32'h200,      0, 32'h0);
    // Ack delayed: request held three cycles at a stable address, single push.
    add(1, 1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0);
    add(0, 1, 0, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0);
    add(0, 1, 0, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0);
    add(0, 0, 1, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0);
    add(0, 0, 0, 0, 0, 32'h0,        0, 32'h4,        1, 32'h0);
    add(0, 0, 0, 1, 0, 32'h0,        0, 32'h4,        1, 32'h0);
    add(0, 0, 0, 0, 0, 32'h0,        0, 32'h4,        0, 32'h0);
    // Redirect while waiting without ack: response dropped, restart at 0x100.
    add(1, 1, 1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0);
    add(0, 1, 1, 1, 0, 32'h0,        1, 32'h0,        0, 32'h0);
    add(0, 1, 1, 1, 0, 32'h0,        1, 32'h4,        1, 32'h0);
    add(0, 1, 0, 1, 1, 32'h100,      1, 32'h8,        1, 32'h4);
    add(0, 1, 0, 1, 0, 32'h0,        1, 32'h8,        0, 32'h0);
    add(0, 1, 1, 1, 0, 32'h0,        1, 32'h8,        0, 32'h0);
    add(0, 1, 0, 1, 0, 32'h0,        0, 32'h100,      0, 32'h0);
    add(0, 1, 1, 1, 0, 32'h0,        1, 32'h100,      0, 32'h0);
    add(0, 1, 0, 1, 0, 32'h0,        1, 32'h104,      1, 32'h100);
    // A second redirect during the drop overwrites the pending target.
    add(1, 1, 1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0);
    add(0, 1, 1, 1, 0, 32'h0,        1, 32'h0,        0, 32'h0);
    add(0, 1, 0, 1, 1, 32'h40,       1, 32'h4,        1, 32'h0);
    add(0, 1, 0, 1, 1, 32'h81,       1, 32'h4,        0, 32'h0);
    add(0, 1, 1, 1, 0, 32'h0,        1, 32'h4,        0, 32'h0);
    add(0, 1, 0, 1, 0, 32'h0,        0, 32'h80,       0, 32'h0);
    add(0, 1, 0, 1, 0, 32'h0,        1, 32'h80,       0, 32'h0);

    // Outputs while held in reset.
    #3;
    check_outputs("in_reset", 1'b0, 32'h0, 1'b0, 32'h0);
    check("in_reset instr_o",    instr_o,    32'h0);
    check("in_reset instr_pc_o", instr_pc_o, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_i);
      if (vecs[i].rst) begin
        rst_i = 1'b0; start_i = 1'b0; imem_ack_i = 1'b0; redirect_i = 1'b0; instr_ready_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
      end
      start_i       = vecs[i].start;
      imem_ack_i    = vecs[i].ack;
      instr_ready_i = vecs[i].ready;
      redirect_i    = vecs[i].redir;
      redirect_pc_i = vecs[i].rpc;
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].ereq, vecs[i].eaddr, vecs[i].evalid, vecs[i].epc);
    end

    // Asynchronous reset mid-request with two entries queued.
    @(negedge clk_i);
    rst_i = 1'b0; start_i = 1'b0; imem_ack_i = 1'b0; redirect_i = 1'b0; instr_ready_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1; start_i = 1'b1; imem_ack_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    @(negedge clk_i);
    imem_ack_i = 1'b0;
    #1;
    check_outputs("pre_arst", 1'b1, 32'h8, 1'b1, 32'h0);
    #1;
    rst_i = 1'b0;
    #1;
    check_outputs("arst", 1'b0, 32'h0, 1'b0, 32'h0);
    check("arst instr_o",    instr_o,    32'h0);
    check("arst instr_pc_o", instr_pc_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check_outputs("restart0", 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk_i);
    #1;
    check_outputs("restart1", 1'b1, 32'h0, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
